userio_osd_cmd: RTL and testbench
=================================

Name: userio_osd_cmd

Overview:
- Command decoder directly downstream of the OSD SPI slave; consumes its received-byte stream (data, rx, cmd, vld) in the clk domain.
- Decodes the first byte of each SPI transaction as a command and subsequent bytes as payload.
- Drives OSD character-buffer writes and OSD control registers.
- Returns a status byte to the SPI slave's parallel input.

Parameters:
- ID, 4'hA, constant returned in status byte bits [7:4].
- LINES_LOG2, 3, log2 of OSD text lines; buffer address width = LINES_LOG2+8.

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- clk7_en  input  1  clock enable; all state updates qualified by it
- vld  input  1  SPI transaction active (synchronised chip select)
- rx  input  1  byte received strobe, high for one clk7_en period
- cmd  input  1  received byte is the first of the transaction
- data  input  8  received byte
- spi_in  output  8  status byte presented to SPI slave parallel input
- wr  output  1  buffer write strobe
- wr_addr  output  LINES_LOG2+8  buffer address {line, column}
- wr_data  output  8  buffer write data
- osd_enable  output  1  OSD display enable
- key_disable  output  1  suppress keyboard forwarding to host
- highlight  output  4  bit3 = highlight valid, [2:0] = highlighted line
- cfg  output  16  configuration word {cfg_hi, cfg_lo}

Behaviour:
- Accept event: a clk edge with clk7_en=1 and rx=1. Nothing else changes state except reset and the vld abort.
- Reset (async, any time, including mid-transaction): state=IDLE; wr=0, wr_addr=0, wr_data=0, osd_enable=0, key_disable=0, highlight=0, cfg=0, column counter=0.
- spi_in is combinational: {ID, 1'b0, osd_enable, key_disable, highlight[3]}. Reset value {ID,4'b0000}.
- States: IDLE, WRLINE, CFG_LO, CFG_HI, IGNORE.
- Accept with cmd=1, from any state, decodes data:
  - 8'b0010_0lll (0x20-0x27): line<=lll, column<=0, go WRLINE.
  - 8'b0100_00ke (0x40-0x43): osd_enable<=e, key_disable<=k, go IGNORE.
  - 8'b0101_vlll (0x50-0x5F): highlight<={v,lll}, go IGNORE.
  - 0x10: go CFG_LO.
  - Any other value: go IGNORE, no register change.
- Accept with cmd=0:
  - WRLINE: wr_addr<={line,column}, wr_data<=data, wr<=1, column<=column+1. Column wraps 255->0 on the same line; it never carries into line.
  - CFG_LO: cfg[7:0]<=data, go CFG_HI.
  - CFG_HI: cfg[15:8]<=data, go IGNORE. cfg_lo and cfg_hi update on separate accepts; no atomic pair.
  - IDLE, IGNORE: byte discarded.
- wr timing:
  - Registered; asserted on the clk7_en edge of the accept.
  - Cleared on the next clk7_en edge; width = exactly one clk7_en period.
  - wr_addr and wr_data stay stable while wr=1 and hold afterwards.
- Latency: all outputs update on the same clk7_en edge as the accepting rx sample (one clk7 period after rx rises).
- vld=0 sampled on a clk7_en edge:
  - state<=IDLE, column<=0; registers already written are kept.
  - If rx=1 on that same edge, the byte is still processed first. State nevertheless ends in IDLE, except a cmd=1 byte, which is decoded normally.
- cmd=1 arriving in WRLINE, CFG_LO or CFG_HI aborts the old command without side effects; the new command is decoded.
- Back-to-back accepts on consecutive clk7_en edges are legal. wr then stays high continuously while wr_addr/wr_data advance each edge.
- clk7_en=0: all state and outputs hold; rx is ignored.

Test Plan:
- Reset mid-WRLINE (after 3 data bytes) -> all outputs zero, spi_in=0xA0; a following data byte with cmd=0 produces no wr.
- Transaction 0x23 then 0x41,0x42,0x43 -> three wr pulses, addresses 0x300,0x301,0x302, data 0x41,0x42,0x43, each one clk7 period wide.
- 0x25 followed by 258 data bytes -> addresses 0x500..0x5FF, then 0x500,0x501; line field stays 5.
- 0x43 -> osd_enable=1, key_disable=1, spi_in=0xA6. Then 0x5E -> highlight=4'hE, spi_in=0xA7.
- 0x10,0x34,0x12,0x99 -> cfg=0x1234, fourth byte ignored. A separate 0x10,0x55 then vld low -> cfg=0x1255.
- Undefined command 0x7F with payload 0x00 -> no output change. 0x21 sent with cmd=1 while in CFG_LO -> cfg unchanged; the next data byte writes address 0x100.

Source files
------------

// File: rtl/userio_osd_cmd.sv
// OSD command decoder fed by the OSD SPI slave byte stream.
// Drives character-buffer writes, OSD control registers and the status byte.
module userio_osd_cmd #(
    parameter logic [3:0] ID         = 4'hA,
    parameter int         LINES_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk7_en,
    input  logic                  vld,
    input  logic                  rx,
    input  logic                  cmd,
    input  logic [7:0]            data,
    output logic [7:0]            spi_in,
    output logic                  wr,
    output logic [LINES_LOG2+7:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  osd_enable,
    output logic                  key_disable,
    output logic [3:0]            highlight,
    output logic [15:0]           cfg
);

    localparam int AW = LINES_LOG2 + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRLINE,
        S_CFG_LO,
        S_CFG_HI,
        S_IGNORE
    } state_e;

    state_e state_q, state_d;

    logic [LINES_LOG2-1:0] line_q, line_d;
    logic [7:0]            col_q, col_d;
    logic                  wr_q, wr_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  osd_q, osd_d;
    logic                  kd_q, kd_d;
    logic [3:0]            hl_q, hl_d;
    logic [15:0]           cfg_q, cfg_d;

    logic cmd_acc;
    logic data_acc;
    logic dec_line;
    logic dec_ctl;
    logic dec_hl;
    logic dec_cfg;

    assign cmd_acc  = clk7_en & rx & cmd;
    assign data_acc = clk7_en & rx & ~cmd;

    assign dec_line = (data[7:3] == 5'b00100);
    assign dec_ctl  = (data[7:2] == 6'b010000);
    assign dec_hl   = (data[7:4] == 4'b0101);
    assign dec_cfg  = (data == 8'h10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A command byte always wins, even when vld drops on the same edge.
    always_comb begin
        state_d = state_q;
        if (clk7_en) begin
            if (cmd_acc) begin
                unique case (1'b1)
                    dec_line: state_d = S_WRLINE;
                    dec_cfg:  state_d = S_CFG_LO;
                    default:  state_d = S_IGNORE;
                endcase
            end else begin
                if (data_acc) begin
                    unique case (state_q)
                        S_CFG_LO: state_d = S_CFG_HI;
                        S_CFG_HI: state_d = S_IGNORE;
                        default:  state_d = state_q;
                    endcase
                end
                if (!vld) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        line_d  = line_q;
        col_d   = col_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        osd_d   = osd_q;
        kd_d    = kd_q;
        hl_d    = hl_q;
        cfg_d   = cfg_q;
        if (clk7_en) begin
            wr_d = 1'b0;
            if (cmd_acc) begin
                unique case (1'b1)
                    dec_line: begin
                        line_d = LINES_LOG2'(data[2:0]);
                        col_d  = 8'd0;
                    end
                    dec_ctl: begin
                        osd_d = data[0];
                        kd_d  = data[1];
                    end
                    dec_hl:  hl_d = data[3:0];
                    default: ;
                endcase
            end else begin
                if (data_acc) begin
                    unique case (state_q)
                        S_WRLINE: begin
                            wr_d    = 1'b1;
                            addr_d  = {line_q, col_q};
                            wdata_d = data;
                            // Column wraps within the line.
                            col_d   = col_q + 8'd1;
                        end
                        S_CFG_LO: cfg_d[7:0]  = data;
                        S_CFG_HI: cfg_d[15:8] = data;
                        default:  ;
                    endcase
                end
                if (!vld) begin
                    col_d = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            col_q   <= 8'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            osd_q   <= 1'b0;
            kd_q    <= 1'b0;
            hl_q    <= 4'd0;
            cfg_q   <= 16'd0;
        end else begin
            line_q  <= line_d;
            col_q   <= col_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            osd_q   <= osd_d;
            kd_q    <= kd_d;
            hl_q    <= hl_d;
            cfg_q   <= cfg_d;
        end
    end

    assign spi_in      = {ID, 1'b0, osd_q, kd_q, hl_q[3]};
    assign wr          = wr_q;
    assign wr_addr     = addr_q;
    assign wr_data     = wdata_q;
    assign osd_enable  = osd_q;
    assign key_disable = kd_q;
    assign highlight   = hl_q;
    assign cfg         = cfg_q;

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Bench for userio_osd_cmd: directed vector table, hand sequences
// and a randomized run against a behavioural model.
module tb_userio_osd_cmd;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        vld;
    logic        rx;
    logic        cmd;
    logic [7:0]  data;
    logic [7:0]  spi_in;
    logic        wr;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        osd_enable;
    logic        key_disable;
    logic [3:0]  highlight;
    logic [15:0] cfg;

    userio_osd_cmd #(.ID(4'hA), .LINES_LOG2(3)) dut (
        .clk(clk),
        .reset(reset),
        .clk7_en(clk7_en),
        .vld(vld),
        .rx(rx),
        .cmd(cmd),
        .data(data),
        .spi_in(spi_in),
        .wr(wr),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .osd_enable(osd_enable),
        .key_disable(key_disable),
        .highlight(highlight),
        .cfg(cfg)
    );

    always #5 clk = ~clk;

    typedef logic [49:0] obs_t;

    obs_t act;
    assign act = {spi_in, wr, wr_addr, wr_data, osd_enable,
                  key_disable, highlight, cfg};

    int passed = 0;
    int total  = 0;

    function automatic obs_t exp_pack(input bit w, input logic [10:0] a,
                                      input logic [7:0] wd, input bit oe,
                                      input bit kd, input logic [3:0] hl,
                                      input logic [15:0] c);
        logic [7:0] st;
        st = {4'hA, 1'b0, oe, kd, hl[3]};
        return {st, w, a, wd, oe, kd, hl, c};
    endfunction

    task automatic chk(input string name, input obs_t exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input bit en, input bit v, input bit r,
                        input bit c, input logic [7:0] d);
        @(negedge clk);
        clk7_en = en;
        vld     = v;
        rx      = r;
        cmd     = c;
        data    = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          en;
        bit          v;
        bit          r;
        bit          c;
        logic [7:0]  d;
        bit          w;
        logic [10:0] a;
        logic [7:0]  wd;
        bit          oe;
        bit          kd;
        logic [3:0]  hl;
        logic [15:0] cf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit en, input bit v, input bit r,
                                input bit c, input logic [7:0] d,
                                input bit w, input logic [10:0] a,
                                input logic [7:0] wd, input bit oe,
                                input bit kd, input logic [3:0] hl,
                                input logic [15:0] cf);
        vec_t x;
        x.en = en; x.v = v; x.r = r; x.c = c; x.d = d;
        x.w = w; x.a = a; x.wd = wd; x.oe = oe; x.kd = kd;
        x.hl = hl; x.cf = cf;
        return x;
    endfunction

    // Behavioural model state
    bit m_inline;
    int m_cfgleft;
    int m_line, m_col;
    bit m_wr;
    int m_addr, m_wd;
    bit m_oe, m_kd;
    int m_hl, m_cfg;

    task automatic model_reset();
        m_inline = 0; m_cfgleft = 0; m_line = 0; m_col = 0;
        m_wr = 0; m_addr = 0; m_wd = 0; m_oe = 0; m_kd = 0;
        m_hl = 0; m_cfg = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit r,
                              input bit c, input logic [7:0] d);
        if (!en) return;
        m_wr = 0;
        if (r && c) begin
            m_inline = 0;
            m_cfgleft = 0;
            if (d >= 8'h20 && d <= 8'h27) begin
                m_inline = 1; m_line = int'(d) - 32; m_col = 0;
            end else if (d >= 8'h40 && d <= 8'h43) begin
                m_oe = d[0]; m_kd = d[1];
            end else if (d >= 8'h50 && d <= 8'h5F) begin
                m_hl = int'(d) - 'h50;
            end else if (d == 8'h10) begin
                m_cfgleft = 2;
            end
        end else begin
            if (r) begin
                if (m_inline) begin
                    m_wr = 1;
                    m_addr = m_line * 256 + m_col;
                    m_wd = int'(d);
                    m_col = (m_col + 1) % 256;
                end else if (m_cfgleft == 2) begin
                    m_cfg = (m_cfg & 'hFF00) | int'(d);
                    m_cfgleft = 1;
                end else if (m_cfgleft == 1) begin
                    m_cfg = (m_cfg & 'hFF) | (int'(d) * 256);
                    m_cfgleft = 0;
                end
            end
            if (!v) begin
                m_inline = 0; m_cfgleft = 0; m_col = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; vld = 1'b0;
        rx = 1'b0; cmd = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", exp_pack(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back(mk(1,1,1,1,8'h23, 0,11'h000,8'h00, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,0,8'h41, 1,11'h300,8'h41, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,0,8'h42, 1,11'h301,8'h42, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(0,1,1,0,8'h55, 1,11'h301,8'h42, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,0,0,8'h00, 0,11'h301,8'h42, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,0,8'h43, 1,11'h302,8'h43, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,0,0,8'h00, 0,11'h302,8'h43, 0,0,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,1,8'h43, 0,11'h302,8'h43, 1,1,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,0,8'h77, 0,11'h302,8'h43, 1,1,4'h0,16'h0000));
        tbl.push_back(mk(1,1,1,1,8'h5E, 0,11'h302,8'h43, 1,1,4'hE,16'h0000));
        tbl.push_back(mk(1,1,1,1,8'h10, 0,11'h302,8'h43, 1,1,4'hE,16'h0000));
        tbl.push_back(mk(1,1,1,0,8'h34, 0,11'h302,8'h43, 1,1,4'hE,16'h0034));
        tbl.push_back(mk(1,1,1,0,8'h12, 0,11'h302,8'h43, 1,1,4'hE,16'h1234));
        tbl.push_back(mk(1,1,1,0,8'h99, 0,11'h302,8'h43, 1,1,4'hE,16'h1234));
        tbl.push_back(mk(1,1,1,1,8'h10, 0,11'h302,8'h43, 1,1,4'hE,16'h1234));
        tbl.push_back(mk(1,1,1,0,8'h55, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,0,8'h66, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,1,8'h7F, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,0,8'h00, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,1,8'h10, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,1,8'h21, 0,11'h302,8'h43, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,0,8'hAB, 1,11'h100,8'hAB, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,0,1,0,8'hCD, 1,11'h101,8'hCD, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,0,8'hEF, 0,11'h101,8'hCD, 1,1,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,1,8'h40, 0,11'h101,8'hCD, 0,0,4'hE,16'h1255));
        tbl.push_back(mk(1,1,1,1,8'h50, 0,11'h101,8'hCD, 0,0,4'h0,16'h1255));
        tbl.push_back(mk(1,0,1,1,8'h22, 0,11'h101,8'hCD, 0,0,4'h0,16'h1255));
        tbl.push_back(mk(1,1,1,0,8'h01, 1,11'h200,8'h01, 0,0,4'h0,16'h1255));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].d);
            chk($sformatf("vec%0d", i),
                exp_pack(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].oe,
                         tbl[i].kd, tbl[i].hl, tbl[i].cf));
        end

        // Asynchronous reset in the middle of a line write
        step(1, 1, 1, 1, 8'h24);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, 0, 8'(8'h60 + k));
        end
        chk("pre_reset_wr", exp_pack(1, 11'h402, 8'h62, 0, 0, 4'h0, 16'h1255));
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset", exp_pack(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 1, 0, 8'h70);
        chk("post_reset_data", exp_pack(0, 0, 0, 0, 0, 0, 0));

        // Column wrap on line 5
        step(1, 1, 1, 1, 8'h25);
        for (int i = 0; i < 258; i++) begin
            step(1, 1, 1, 0, 8'(i));
            chk($sformatf("wrap%0d", i),
                exp_pack(1, 11'(11'h500 + (i % 256)), 8'(i), 0, 0, 0, 0));
        end
        step(1, 1, 0, 0, 8'h00);
        chk("wrap_end", exp_pack(0, 11'h501, 8'h01, 0, 0, 0, 0));

        // Randomized run against the model
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit en, v, r, c;
            logic [7:0] d;
            en = ($urandom_range(0, 9) < 7);
            v  = ($urandom_range(0, 19) != 0);
            r  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 3) == 0);
            if (c) begin
                case ($urandom_range(0, 4))
                    0: d = 8'(8'h20 + $urandom_range(0, 7));
                    1: d = 8'(8'h40 + $urandom_range(0, 3));
                    2: d = 8'(8'h50 + $urandom_range(0, 15));
                    3: d = 8'h10;
                    default: d = 8'($urandom);
                endcase
            end else begin
                d = 8'($urandom);
            end
            step(en, v, r, c, d);
            model_step(en, v, r, c, d);
            chk($sformatf("rand%0d", n),
                exp_pack(m_wr, 11'(m_addr), 8'(m_wd), m_oe, m_kd,
                         4'(m_hl), 16'(m_cfg)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
